ucie_ctl_rdi_tx_buffer: RTL

//  Adapter-side transmit buffer directly upstream of the PHY RDI data path: accepts flit chunks from the

---
 rtl/ucie_ctl_pkg.sv | 38 +++
 rtl/ucie_ctl_sync_fifo.sv | 64 ++++++
 rtl/ucie_ctl_rdi_tx_buffer.sv | 115 +++++++++++
 3 files changed

// File: rtl/ucie_ctl_pkg.sv
// ============================================================================
// Package : ucie_ctl_pkg
// Brief   : RDI status encodings, error-class helper and TX buffer FSM states
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package ucie_ctl_pkg;

  // RDI pl_state_sts encodings
  localparam logic [3:0] STS_RESET     = 4'b0000;
  localparam logic [3:0] STS_ACTIVE    = 4'b0001;
  localparam logic [3:0] STS_L1        = 4'b0100;
  localparam logic [3:0] STS_L2        = 4'b1000;
  localparam logic [3:0] STS_LINKRESET = 4'b1001;
  localparam logic [3:0] STS_LINKERROR = 4'b1010;
  localparam logic [3:0] STS_RETRAIN   = 4'b1011;
  localparam logic [3:0] STS_DISABLED  = 4'b1100;

  // Buffer control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fsm_e;

  // Status codes after which buffered beats can no longer be delivered
  function automatic logic is_err_sts(input logic [3:0] sts);
    return (sts == STS_RESET)     ||
           (sts == STS_LINKRESET) ||
           (sts == STS_LINKERROR) ||
           (sts == STS_DISABLED);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ucie_ctl_sync_fifo.sv
// ============================================================================
// Module  : ucie_ctl_sync_fifo
// Brief   : Single-clock FIFO of NBYTES-wide beats with synchronous clear
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ucie_ctl_sync_fifo #(
  parameter  int NBYTES = 32,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [NBYTES-1:0][7:0] wdata,
  output logic [NBYTES-1:0][7:0] rdata,
  output logic [CW-1:0]          count
);

  logic [NBYTES-1:0][7:0] mem [DEPTH];
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          wr_ptr;

  // Storage is left unreset; only pointers/occupancy define what is valid
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/ucie_ctl_rdi_tx_buffer.sv
// ============================================================================
// Module  : ucie_ctl_rdi_tx_buffer
// Brief   : Adapter-side TX buffer feeding the PHY RDI data path. Drains only
//           while RDI is Active, holds across Retrain/PM, discards on error.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ucie_ctl_rdi_tx_buffer
  import ucie_ctl_pkg::*;
#(
  parameter  int NBYTES = 32,
  parameter  int DEPTH  = 4,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NBYTES-1:0][7:0] i_data,
  input  logic                   i_data_valid,
  output logic                   o_data_ready,
  input  logic [3:0]             i_rdi_pl_state_sts,
  input  logic                   i_rdi_pl_trdy,
  output logic                   o_rdi_lp_irdy,
  output logic                   o_rdi_lp_valid,
  output logic [NBYTES-1:0][7:0] o_rdi_lp_data,
  output logic [CW-1:0]          o_count,
  output logic                   o_flush_pulse,
  output logic [CW-1:0]          o_flush_drops
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fsm_e                   state;
  logic [CW-1:0]          count;
  logic [CW-1:0]          flush_drops;
  logic [NBYTES-1:0][7:0] head;
  logic                   sts_active;
  logic                   sts_err;
  logic                   push;
  logic                   pop;
  logic                   clr;
  logic                   lp_valid;

  assign sts_active = (i_rdi_pl_state_sts == STS_ACTIVE);
  assign sts_err    = is_err_sts(i_rdi_pl_state_sts);

  // Intake depends only on state and occupancy, never on the PHY's trdy
  assign o_data_ready = ((state == RUN) || (state == HOLD)) && (count < DEPTH_C);

  // Current status gates valid so a status drop blocks a pop in that same cycle
  assign lp_valid       = (state == RUN) && (count != '0) && sts_active;
  assign o_rdi_lp_valid = lp_valid;
  assign o_rdi_lp_irdy  = lp_valid;
  assign o_rdi_lp_data  = lp_valid ? head : '0;

  assign push = i_data_valid && o_data_ready;
  assign pop  = lp_valid && i_rdi_pl_trdy;
  assign clr  = (state == FLUSH);

  assign o_count       = count;
  assign o_flush_pulse = (state == FLUSH);
  assign o_flush_drops = flush_drops;

  // Link-state tracking; the FLUSH cycle records how many beats are being dropped
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      flush_drops <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sts_active) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (sts_err) begin
            state <= FLUSH;
          end else if (!sts_active) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (sts_err) begin
            state <= FLUSH;
          end else if (sts_active) begin
            state <= RUN;
          end
        end
        FLUSH: begin
          flush_drops <= count;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ucie_ctl_sync_fifo #(
    .NBYTES (NBYTES),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata (i_data),
    .rdata (head),
    .count (count)
  );

endmodule

`default_nettype wire
